// File: rtl/match_controller_if.sv
// Signal bundle between the match controller and the rest of the game.
// Groups the top-level start button, the game core's health outputs and
// everything the controller drives back (core reset, input gate, overlay data).
// The "master" side is the surrounding top level; the "slave" side is the
// controller itself.
interface match_controller_if;
  logic       start_btn;
  logic [3:0] p1_health;
  logic [3:0] p2_health;
  logic       game_rst_n;
  logic       input_enable;
  logic [2:0] state;
  logic [3:0] countdown;
  logic [6:0] round_timer;
  logic [2:0] round_num;
  logic [1:0] p1_rounds;
  logic [1:0] p2_rounds;
  logic [1:0] round_result;
  logic [1:0] winner;

  modport master (
    output start_btn, p1_health, p2_health,
    input  game_rst_n, input_enable, state, countdown, round_timer,
    input  round_num, p1_rounds, p2_rounds, round_result, winner
  );

  modport slave (
    input  start_btn, p1_health, p2_health,
    output game_rst_n, input_enable, state, countdown, round_timer,
    output round_num, p1_rounds, p2_rounds, round_result, winner
  );
endinterface

// File: rtl/match_controller.sv
// Match sequencer in front of the game core.
// Owns the core's active-low reset, gates player inputs and walks each match
// through IDLE -> ROUND_RESET -> COUNTDOWN -> FIGHT -> ROUND_END -> ... ->
// MATCH_OVER. Rounds end on KO (a health output at zero) and, when the
// MATCH_TIMER_EN macro is defined, on round-timer expiry. With MATCH_TIMER_EN
// undefined the round timer reads 0 and only KOs end a round.
// All outputs are registered and move on the same edge as the state.
module match_controller #(
  parameter int TICK_CYCLES       = 100_000_000,
  parameter int ROUND_SECONDS     = 60,
  parameter int COUNTDOWN_SECONDS = 3,
  parameter int KO_HOLD_SECONDS   = 2,
  parameter int GAME_RST_CYCLES   = 1_000_000,
  parameter int ROUNDS_TO_WIN     = 2,
  parameter int MAX_ROUNDS        = 5
) (
  input  logic               clk,
  input  logic               reset,
  match_controller_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    ROUND_RESET = 3'd1,
    COUNTDOWN   = 3'd2,
    FIGHT       = 3'd3,
    ROUND_END   = 3'd4,
    MATCH_OVER  = 3'd5
  } state_t;

  localparam logic [1:0] RES_NONE = 2'd0;
  localparam logic [1:0] RES_P1   = 2'd1;
  localparam logic [1:0] RES_P2   = 2'd2;
  localparam logic [1:0] RES_DRAW = 2'd3;

  // One counter serves both as the second prescaler and as the core-reset
  // pulse timer, so it must be wide enough for the longer of the two.
  localparam int CNT_MAX = (TICK_CYCLES > GAME_RST_CYCLES) ? TICK_CYCLES : GAME_RST_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_CYCLES - 1);
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(GAME_RST_CYCLES - 1);

  localparam int HOLD_W = (KO_HOLD_SECONDS > 1) ? $clog2(KO_HOLD_SECONDS + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(KO_HOLD_SECONDS - 1);

  localparam logic [3:0] CD_LOAD   = 4'(COUNTDOWN_SECONDS);
  localparam logic [2:0] LAST_ROUND = 3'(MAX_ROUNDS);
  localparam logic [1:0] WIN_ROUNDS = 2'(ROUNDS_TO_WIN);
`ifdef MATCH_TIMER_EN
  localparam logic [6:0] RT_LOAD = 7'(ROUND_SECONDS);
`else
  localparam logic [6:0] RT_LOAD = 7'd0;
`endif

  state_t            state_q;
  logic              start_q;
  logic              start_edge_q;
  logic [3:0]        h1_q;
  logic [3:0]        h2_q;
  logic [CNT_W-1:0]  presc_q;
  logic [HOLD_W-1:0] hold_q;
  logic              game_rst_n_q;
  logic              input_enable_q;
  logic [3:0]        countdown_q;
  logic [6:0]        round_timer_q;
  logic [2:0]        round_num_q;
  logic [1:0]        p1_rounds_q;
  logic [1:0]        p2_rounds_q;
  logic [1:0]        round_result_q;
  logic [1:0]        winner_q;

  logic              tick;
  logic              fight_end;
  logic [1:0]        fight_result;
  logic              match_done;

  // Round win counter; a 2-bit score never wraps back to zero.
  function automatic logic [1:0] sat_inc(input logic [1:0] v);
    return (v == 2'd3) ? 2'd3 : v + 2'd1;
  endfunction

  // KO outcome: the side left standing wins, a double KO is a draw.
  function automatic logic [1:0] ko_result(input logic [3:0] h1, input logic [3:0] h2);
    if (h1 == 4'd0 && h2 == 4'd0) return RES_DRAW;
    else if (h2 == 4'd0)          return RES_P1;
    else                          return RES_P2;
  endfunction

  // Time-out outcome: more health wins, equal health is a draw.
  function automatic logic [1:0] timeout_result(input logic [3:0] h1, input logic [3:0] h2);
    if (h1 > h2)      return RES_P1;
    else if (h2 > h1) return RES_P2;
    else              return RES_DRAW;
  endfunction

  // Match winner from the final round counts.
  function automatic logic [1:0] match_winner(input logic [1:0] r1, input logic [1:0] r2);
    if (r1 > r2)      return RES_P1;
    else if (r2 > r1) return RES_P2;
    else              return RES_DRAW;
  endfunction

  assign tick       = (presc_q == TICK_LAST);
  assign match_done = (p1_rounds_q >= WIN_ROUNDS) || (p2_rounds_q >= WIN_ROUNDS) ||
                      (round_num_q == LAST_ROUND);

  // Register the core's health once; every decision uses these copies.
  always_ff @(posedge clk) begin
    h1_q <= bus.p1_health;
    h2_q <= bus.p2_health;
  end

  // Registered rising-edge detect on the debounced start button.
  always_ff @(posedge clk) begin
    if (!reset) begin
      start_q      <= 1'b0;
      start_edge_q <= 1'b0;
    end else begin
      start_q      <= bus.start_btn;
      start_edge_q <= bus.start_btn & ~start_q;
    end
  end

  // Round-ending condition while fighting; a KO outranks a same-cycle time-out.
  always_comb begin
    fight_end    = 1'b0;
    fight_result = RES_NONE;
    if (h1_q == 4'd0 || h2_q == 4'd0) begin
      fight_end    = 1'b1;
      fight_result = ko_result(h1_q, h2_q);
    end
`ifdef MATCH_TIMER_EN
    else if (tick && round_timer_q == 7'd1) begin
      fight_end    = 1'b1;
      fight_result = timeout_result(h1_q, h2_q);
    end
`endif
  end

  // Match FSM with all overlay/core-control outputs registered alongside it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= IDLE;
      presc_q        <= '0;
      hold_q         <= '0;
      game_rst_n_q   <= 1'b0;
      input_enable_q <= 1'b0;
      countdown_q    <= CD_LOAD;
      round_timer_q  <= RT_LOAD;
      round_num_q    <= 3'd1;
      p1_rounds_q    <= 2'd0;
      p2_rounds_q    <= 2'd0;
      round_result_q <= RES_NONE;
      winner_q       <= RES_NONE;
    end else begin
      // Free-running prescaler; the core-reset phase counts straight through
      // instead of wrapping. Every state entry below restarts it at zero.
      if (state_q == ROUND_RESET || !tick) presc_q <= presc_q + 1'b1;
      else                                 presc_q <= '0;

      case (state_q)
        IDLE: begin
          if (start_edge_q) begin
            state_q        <= ROUND_RESET;
            presc_q        <= '0;
            game_rst_n_q   <= 1'b0;
            input_enable_q <= 1'b0;
            countdown_q    <= CD_LOAD;
            round_timer_q  <= RT_LOAD;
            round_num_q    <= 3'd1;
            p1_rounds_q    <= 2'd0;
            p2_rounds_q    <= 2'd0;
            round_result_q <= RES_NONE;
            winner_q       <= RES_NONE;
          end
        end

        ROUND_RESET: begin
          // Core reset has been low for exactly GAME_RST_CYCLES cycles.
          if (presc_q == RST_LAST) begin
            state_q      <= COUNTDOWN;
            presc_q      <= '0;
            game_rst_n_q <= 1'b1;
          end
        end

        COUNTDOWN: begin
          if (tick) begin
            if (countdown_q == 4'd1) begin
              countdown_q    <= 4'd0;
              state_q        <= FIGHT;
              presc_q        <= '0;
              input_enable_q <= 1'b1;
            end else begin
              countdown_q <= countdown_q - 4'd1;
            end
          end
        end

        FIGHT: begin
`ifdef MATCH_TIMER_EN
          if (tick && round_timer_q != 7'd0) round_timer_q <= round_timer_q - 7'd1;
`endif
          if (fight_end) begin
            state_q        <= ROUND_END;
            presc_q        <= '0;
            hold_q         <= '0;
            input_enable_q <= 1'b0;
            round_result_q <= fight_result;
            if (fight_result == RES_P1) p1_rounds_q <= sat_inc(p1_rounds_q);
            if (fight_result == RES_P2) p2_rounds_q <= sat_inc(p2_rounds_q);
          end
        end

        ROUND_END: begin
          // Core stays frozen (out of reset, inputs gated) for the hold time.
          if (tick) begin
            if (hold_q == HOLD_LAST) begin
              hold_q  <= '0;
              presc_q <= '0;
              if (match_done) begin
                state_q  <= MATCH_OVER;
                winner_q <= match_winner(p1_rounds_q, p2_rounds_q);
              end else begin
                state_q       <= ROUND_RESET;
                round_num_q   <= round_num_q + 3'd1;
                game_rst_n_q  <= 1'b0;
                countdown_q   <= CD_LOAD;
                round_timer_q <= RT_LOAD;
              end
            end else begin
              hold_q <= hold_q + 1'b1;
            end
          end
        end

        MATCH_OVER: begin
          if (start_edge_q) begin
            state_q        <= IDLE;
            presc_q        <= '0;
            game_rst_n_q   <= 1'b0;
            input_enable_q <= 1'b0;
            p1_rounds_q    <= 2'd0;
            p2_rounds_q    <= 2'd0;
            round_result_q <= RES_NONE;
            winner_q       <= RES_NONE;
          end
        end

        default: begin
          state_q        <= IDLE;
          presc_q        <= '0;
          game_rst_n_q   <= 1'b0;
          input_enable_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.state        = state_q;
  assign bus.game_rst_n   = game_rst_n_q;
  assign bus.input_enable = input_enable_q;
  assign bus.countdown    = countdown_q;
  assign bus.round_timer  = round_timer_q;
  assign bus.round_num    = round_num_q;
  assign bus.p1_rounds    = p1_rounds_q;
  assign bus.p2_rounds    = p2_rounds_q;
  assign bus.round_result = round_result_q;
  assign bus.winner       = winner_q;

endmodule

// File: tb/tb_match_controller.sv
// Scoreboard bench for match_controller.
// The stimulus thread pushes every expected output change (full output
// snapshot plus cycles since the previous change) into a queue before it
// provokes it; the monitor pops and compares whenever any output changes.
module tb_match_controller;

  localparam int TICK  = 4;
  localparam int RSEC  = 5;
  localparam int CSEC  = 3;
  localparam int HSEC  = 2;
  localparam int GRST  = 8;
  localparam int RTW   = 2;
  localparam int MAXR  = 3;
`ifdef MATCH_TIMER_EN
  localparam logic [6:0] RT_LOAD = 7'd5;
`else
  localparam logic [6:0] RT_LOAD = 7'd0;
`endif

  localparam logic [2:0] S_IDLE = 3'd0, S_RR = 3'd1, S_CD = 3'd2,
                         S_FIGHT = 3'd3, S_END = 3'd4, S_OVER = 3'd5;

  typedef struct packed {
    logic [2:0] st;
    logic       grn;
    logic       ien;
    logic [3:0] cd;
    logic [6:0] rt;
    logic [2:0] rn;
    logic [1:0] p1r;
    logic [1:0] p2r;
    logic [1:0] rr;
    logic [1:0] win;
  } snap_t;

  typedef struct {
    snap_t s;
    int    gap;
    string tag;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  match_controller_if bus();

  match_controller #(
    .TICK_CYCLES(TICK), .ROUND_SECONDS(RSEC), .COUNTDOWN_SECONDS(CSEC),
    .KO_HOLD_SECONDS(HSEC), .GAME_RST_CYCLES(GRST), .ROUNDS_TO_WIN(RTW),
    .MAX_ROUNDS(MAXR)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  exp_t  expq[$];
  int    checks = 0;
  int    errors = 0;
  bit    mon_en = 1'b0;
  snap_t m;

  function automatic snap_t cur_snap();
    snap_t s;
    s.st  = bus.state;
    s.grn = bus.game_rst_n;
    s.ien = bus.input_enable;
    s.cd  = bus.countdown;
    s.rt  = bus.round_timer;
    s.rn  = bus.round_num;
    s.p1r = bus.p1_rounds;
    s.p2r = bus.p2_rounds;
    s.rr  = bus.round_result;
    s.win = bus.winner;
    return s;
  endfunction

  function automatic string fmt(input snap_t s);
    return $sformatf("st=%0d grn=%0d ien=%0d cd=%0d rt=%0d rn=%0d p1r=%0d p2r=%0d rr=%0d win=%0d",
                     s.st, s.grn, s.ien, s.cd, s.rt, s.rn, s.p1r, s.p2r, s.rr, s.win);
  endfunction

  task automatic check_snap(input string tag, input snap_t act, input snap_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual {%s} required {%s}", tag, fmt(act), fmt(exp));
    end
  endtask

  task automatic push(input string tag, input int gap);
    exp_t e;
    e.s   = m;
    e.gap = gap;
    e.tag = tag;
    expq.push_back(e);
  endtask

  // Expected changes from entering ROUND_RESET up to entering FIGHT.
  task automatic round_start_exp(input int first_gap);
    m.st = S_RR; m.grn = 1'b0; m.ien = 1'b0; m.cd = 4'd3; m.rt = RT_LOAD;
    push("round_reset_entry", first_gap);
    m.st = S_CD; m.grn = 1'b1;
    push("countdown_entry", GRST);
    m.cd = 4'd2; push("countdown_2", TICK);
    m.cd = 4'd1; push("countdown_1", TICK);
    m.cd = 4'd0; m.st = S_FIGHT; m.ien = 1'b1;
    push("fight_entry", TICK);
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
    int n = 0;
    while (bus.state !== s && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (bus.state !== s) begin
      checks++;
      errors++;
      $display("FAIL wait_%s: state=%0d required %0d within %0d cycles", tag, bus.state, s, budget);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) bus.start_btn = 1'b1;
    @(negedge clk) bus.start_btn = 1'b0;
    @(posedge clk); #1;
  endtask

  // Monitor: every output change must match the next queued expectation.
  initial begin
    snap_t prev, cur;
    exp_t  e;
    int    cyc;
    wait (mon_en);
    prev = cur_snap();
    cyc  = 0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      cur = cur_snap();
      if (cur !== prev) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_change: actual {%s} required no change", fmt(cur));
        end else begin
          e = expq.pop_front();
          check_snap(e.tag, cur, e.s);
          if (e.gap >= 0) begin
            checks++;
            if (cyc != e.gap) begin
              errors++;
              $display("FAIL %s_latency: actual %0d cycles required %0d", e.tag, cyc, e.gap);
            end
          end
        end
        prev = cur;
        cyc  = 0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, %0d expectations pending", expq.size());
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start_btn = 1'b0;
    bus.p1_health = 4'd15;
    bus.p2_health = 4'd15;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    m = '{st: S_IDLE, grn: 1'b0, ien: 1'b0, cd: 4'd3, rt: RT_LOAD, rn: 3'd1,
          p1r: 2'd0, p2r: 2'd0, rr: 2'd0, win: 2'd0};
    check_snap("reset_values", cur_snap(), m);
    mon_en = 1'b1;

    // Match 1, round 1: P1 wins by KO.
    round_start_exp(-1);
    pulse_start();
    wait_state(S_FIGHT, 100, "fight_r1");
    m.st = S_END; m.ien = 1'b0; m.rr = 2'd1; m.p1r = 2'd1;
    push("ko_p2", 2);
    bus.p2_health = 4'd0;
    wait_state(S_END, 10, "end_r1");
    bus.p1_health = 4'd7;
    bus.p2_health = 4'd9;

    // Round 2: P2 takes it; a start press in COUNTDOWN is ignored.
    m.rn = 3'd2;
    round_start_exp(TICK * HSEC);
    wait_state(S_CD, 40, "cd_r2");
    pulse_start();
    wait_state(S_FIGHT, 100, "fight_r2");
`ifdef MATCH_TIMER_EN
    for (int t = 4; t >= 1; t--) begin
      m.rt = 7'(t);
      push("round_timer_dec", TICK);
    end
    m.rt = 7'd0; m.st = S_END; m.ien = 1'b0; m.rr = 2'd2; m.p2r = 2'd1;
    push("timeout_p2", TICK);
    wait_state(S_END, 40, "end_r2");
`else
    m.st = S_END; m.ien = 1'b0; m.rr = 2'd2; m.p2r = 2'd1;
    push("ko_p1", 2);
    bus.p1_health = 4'd0;
    wait_state(S_END, 10, "end_r2");
`endif
    bus.p1_health = 4'd9;
    bus.p2_health = 4'd9;

    // Round 3: P1 reaches two wins and takes the match.
    m.rn = 3'd3;
    round_start_exp(TICK * HSEC);
    wait_state(S_FIGHT, 100, "fight_r3");
    m.st = S_END; m.ien = 1'b0; m.rr = 2'd1; m.p1r = 2'd2;
    push("ko_p2_match_point", 2);
    bus.p2_health = 4'd0;
    wait_state(S_END, 10, "end_r3");
    bus.p2_health = 4'd9;
    m.st = S_OVER; m.win = 2'd1;
    push("match_over_p1", TICK * HSEC);
    wait_state(S_OVER, 20, "over_m1");

    m.st = S_IDLE; m.grn = 1'b0; m.p1r = 2'd0; m.p2r = 2'd0; m.rr = 2'd0; m.win = 2'd0;
    push("over_to_idle", -1);
    pulse_start();

    // Match 2: stale zero health outside FIGHT, three double KOs, round limit.
    bus.p1_health = 4'd0;
    bus.p2_health = 4'd0;
    m.rn = 3'd1;
    round_start_exp(-1);
    for (int r = 1; r <= 3; r++) begin
      m.st = S_END; m.ien = 1'b0; m.rr = 2'd3;
      push("double_ko", 1);
      if (r < 3) begin
        m.rn = 3'(r + 1);
        round_start_exp(TICK * HSEC);
      end else begin
        m.st = S_OVER; m.win = 2'd3;
        push("match_over_draw", TICK * HSEC);
      end
    end
    pulse_start();
    wait_state(S_OVER, 300, "over_m2");

    m.st = S_IDLE; m.grn = 1'b0; m.rr = 2'd0; m.win = 2'd0;
    push("draw_to_idle", -1);
    pulse_start();

    // Match 3: reset pulled low in the middle of round 2's fight.
    bus.p1_health = 4'd15;
    bus.p2_health = 4'd15;
    m.rn = 3'd1;
    round_start_exp(-1);
    pulse_start();
    wait_state(S_FIGHT, 100, "fight_m3r1");
    m.st = S_END; m.ien = 1'b0; m.rr = 2'd1; m.p1r = 2'd1;
    push("ko_p2_m3", 2);
    bus.p2_health = 4'd0;
    wait_state(S_END, 10, "end_m3r1");
    bus.p2_health = 4'd15;
    m.rn = 3'd2;
    round_start_exp(TICK * HSEC);
    wait_state(S_FIGHT, 100, "fight_m3r2");
    m = '{st: S_IDLE, grn: 1'b0, ien: 1'b0, cd: 4'd3, rt: RT_LOAD, rn: 3'd1,
          p1r: 2'd0, p2r: 2'd0, rr: 2'd0, win: 2'd0};
    push("mid_match_reset", 1);
    reset = 1'b0;
    @(posedge clk); #1;
    @(negedge clk) reset = 1'b1;
    repeat (6) @(posedge clk);
    #1;

    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL pending_expectations: actual %0d left required 0 (next %s)",
               expq.size(), expq[0].tag);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
